// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined shifter: mode encodings, mode legality
// and the placement of pipeline register banks along the stage chain.
package shift_pkg;

  localparam logic [2:0] MODE_LSL = 3'd0;
  localparam logic [2:0] MODE_LSR = 3'd1;
  localparam logic [2:0] MODE_ASL = 3'd2;
  localparam logic [2:0] MODE_ASR = 3'd3;
  localparam logic [2:0] MODE_ROL = 3'd4;
  localparam logic [2:0] MODE_ROR = 3'd5;

  function automatic logic mode_legal(input logic [2:0] mode);
    return (mode <= MODE_ROR);
  endfunction

  // True when a register bank sits after chain position idx; banks are spread
  // evenly and the last one always terminates the chain.
  function automatic logic reg_after(input int idx, input int nstages, input int pipe);
    logic hit;
    hit = 1'b0;
    for (int b = 0; b < pipe; b++) begin
      if ((((b + 1) * nstages) / pipe) - 1 == idx) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One combinational step of the barrel shifter: when enabled, shifts/rotates by
// 2**K with the fill for the mode, tracking carry-out and ASL sign overflow.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int K     = 0
) (
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data,
  input  logic             carry,
  input  logic             ovf,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             res_ovf
);

  localparam int N   = 2 ** K;
  // Bits that pass through the sign position during this step, capped at the word.
  localparam int WIN = (N + 1 > WIDTH) ? WIDTH : N + 1;

  logic [WIDTH-1:0] lsl, lsr, asr, rol, ror;
  logic [WIN-1:0]   top;
  logic             top_mixed;

  always_comb begin
    lsl       = data << N;
    lsr       = data >> N;
    asr       = $unsigned($signed(data) >>> N);
    rol       = (data << N) | (data >> (WIDTH - N));
    ror       = (data >> N) | (data << (WIDTH - N));
    top       = data[WIDTH-1 -: WIN];
    top_mixed = (top != {WIN{data[WIDTH-1]}});

    res_data  = data;
    res_carry = carry;
    res_ovf   = ovf;
    if (en) begin
      case (mode)
        MODE_LSL: begin
          res_data  = lsl;
          res_carry = data[WIDTH-N];
        end
        MODE_ASL: begin
          res_data  = lsl;
          res_carry = data[WIDTH-N];
          res_ovf   = ovf | top_mixed;
        end
        MODE_LSR: begin
          res_data  = lsr;
          res_carry = data[N-1];
        end
        MODE_ASR: begin
          res_data  = asr;
          res_carry = data[N-1];
        end
        MODE_ROL: begin
          res_data  = rol;
          res_carry = rol[0];
        end
        MODE_ROR: begin
          res_data  = ror;
          res_carry = ror[WIDTH-1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter/rotator with a valid/ready stream on both sides.
// All register banks advance together whenever the output is free or consumed.
module shift_unit_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PIPE  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [$clog2(WIDTH):0] in_shamt,
  input  logic [2:0]             in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_carry,
  output logic                   out_ovf,
  output logic                   out_err
);

  localparam int SHW = $clog2(WIDTH) + 1;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   shamt;
    logic [2:0]       mode;
    logic             carry;
    logic             ovf;
    logic             err;
  } beat_t;

  beat_t head;
  beat_t tail;
  logic  adv;
  logic  tail_unused;

  always_comb begin
    head       = '0;
    head.valid = in_valid;
    head.data  = in_data;
    head.shamt = in_shamt;
    head.mode  = in_mode;
    head.err   = ~mode_legal(in_mode);
  end

  // The shift-by-WIDTH step goes first so the ASL overflow window only ever
  // sees original operand bits, never zero fill from smaller steps.
  for (genvar j = 0; j < SHW; j++) begin : g_chain
    localparam int K = SHW - 1 - j;

    beat_t            cur;
    beat_t            comb;
    beat_t            nxt;
    logic [WIDTH-1:0] st_data;
    logic             st_carry;
    logic             st_ovf;

    if (j == 0) begin : g_head
      assign cur = head;
    end else begin : g_link
      assign cur = g_chain[j-1].nxt;
    end

    shift_stage #(.WIDTH(WIDTH), .K(K)) u_stage (
      .en        (cur.shamt[K]),
      .mode      (cur.mode),
      .data      (cur.data),
      .carry     (cur.carry),
      .ovf       (cur.ovf),
      .res_data  (st_data),
      .res_carry (st_carry),
      .res_ovf   (st_ovf)
    );

    always_comb begin
      comb       = cur;
      comb.data  = st_data;
      comb.carry = st_carry;
      comb.ovf   = st_ovf;
    end

    if (reg_after(j, SHW, PIPE)) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst)      nxt <= '0;
        else if (adv) nxt <= comb;
      end
    end else begin : g_wire
      assign nxt = comb;
    end
  end

  assign tail        = g_chain[SHW-1].nxt;
  assign tail_unused = ^{tail.shamt, tail.mode};

  assign out_valid = tail.valid;
  assign out_data  = tail.data;
  assign out_carry = tail.carry;
  assign out_ovf   = tail.ovf;
  assign out_err   = tail.err;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Self-checking bench for shift_unit_pipe (WIDTH=8, PIPE=2): directed vectors,
// back-to-back stream, output stall and mid-flight reset against a scoreboard.
module tb_shift_unit_pipe;
  import shift_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [3:0] in_shamt = '0;
  logic [2:0] in_mode = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_carry;
  logic       out_ovf;
  logic       out_err;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       carry;
    logic       ovf;
    logic       err;
  } exp_t;

  typedef struct packed {
    logic [2:0] mode;
    logic [7:0] data;
    logic [3:0] shamt;
    logic [7:0] exp_data;
    logic       exp_c;
    logic       exp_o;
    logic       exp_e;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  shift_unit_pipe #(.WIDTH(8), .PIPE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .out_err   (out_err)
  );

  // Reference model written straight from the shift rules, one formula per mode.
  function automatic exp_t model(input logic [2:0] m, input logic [7:0] d, input logic [3:0] s);
    exp_t             r;
    int               si;
    int               n;
    logic [15:0]      tmp;
    logic signed [7:0] sd;
    r  = '0;
    si = int'(s);
    sd = d;
    case (m)
      MODE_LSL, MODE_ASL: begin
        r.data  = (si >= 8) ? 8'h00 : (d << si);
        r.carry = (si == 0 || si > 8) ? 1'b0 : d[8-si];
        if (m == MODE_ASL) begin
          n = (si + 1 > 8) ? 8 : si + 1;
          for (int i = 0; i < n; i++) if (d[7-i] != d[7]) r.ovf = 1'b1;
        end
      end
      MODE_LSR: begin
        r.data  = (si >= 8) ? 8'h00 : (d >> si);
        r.carry = (si == 0 || si > 8) ? 1'b0 : d[si-1];
      end
      MODE_ASR: begin
        if (si >= 8) begin
          r.data  = {8{d[7]}};
          r.carry = d[7];
        end else begin
          r.data  = $unsigned(sd >>> si);
          r.carry = (si == 0) ? 1'b0 : d[si-1];
        end
      end
      MODE_ROL: begin
        tmp     = {d, d} << (si % 8);
        r.data  = tmp[15:8];
        r.carry = (si == 0) ? 1'b0 : r.data[0];
      end
      MODE_ROR: begin
        tmp     = {d, d} >> (si % 8);
        r.data  = tmp[7:0];
        r.carry = (si == 0) ? 1'b0 : r.data[7];
      end
      default: begin
        r.data = d;
        r.err  = 1'b1;
      end
    endcase
    return r;
  endfunction

  // Scoreboard: push on accept, pop and compare on consume.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) sb.push_back(model(in_mode, in_data, in_shamt));
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_extra: unexpected beat data=%h with empty scoreboard", out_data);
        end else begin
          mon_e = sb.pop_front();
          if ({out_data, out_carry, out_ovf, out_err} !== {mon_e.data, mon_e.carry, mon_e.ovf, mon_e.err}) begin
            failures++;
            $display("FAIL sb_beat: got data=%h c=%b o=%b e=%b, expected data=%h c=%b o=%b e=%b",
                     out_data, out_carry, out_ovf, out_err, mon_e.data, mon_e.carry, mon_e.ovf, mon_e.err);
          end
        end
      end
    end
  end

  task automatic test_reset();
    out_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if ({out_data, out_carry, out_ovf, out_err} !== 11'h0) begin
      failures++;
      $display("FAIL reset_outputs: got data=%h c=%b o=%b e=%b expected all 0", out_data, out_carry, out_ovf, out_err);
    end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_vectors();
    vec_t vecs[15];
    int   lat;
    logic got;
    vecs = '{
      '{MODE_LSL, 8'h81, 4'd1,  8'h02, 1'b1, 1'b0, 1'b0},
      '{MODE_LSR, 8'h81, 4'd8,  8'h00, 1'b1, 1'b0, 1'b0},
      '{MODE_LSR, 8'h81, 4'd9,  8'h00, 1'b0, 1'b0, 1'b0},
      '{MODE_ASR, 8'h80, 4'd3,  8'hF0, 1'b0, 1'b0, 1'b0},
      '{MODE_ASR, 8'h80, 4'd12, 8'hFF, 1'b1, 1'b0, 1'b0},
      '{MODE_ASL, 8'h40, 4'd1,  8'h80, 1'b0, 1'b1, 1'b0},
      '{MODE_ASL, 8'h20, 4'd1,  8'h40, 1'b0, 1'b0, 1'b0},
      '{MODE_ROR, 8'h01, 4'd1,  8'h80, 1'b1, 1'b0, 1'b0},
      '{MODE_ROR, 8'h01, 4'd9,  8'h80, 1'b1, 1'b0, 1'b0},
      '{MODE_ROL, 8'hA5, 4'd8,  8'hA5, 1'b1, 1'b0, 1'b0},
      '{MODE_ROL, 8'hA5, 4'd0,  8'hA5, 1'b0, 1'b0, 1'b0},
      '{3'd6,     8'h3C, 4'd5,  8'h3C, 1'b0, 1'b0, 1'b1},
      '{3'd7,     8'h3C, 4'd3,  8'h3C, 1'b0, 1'b0, 1'b1},
      '{MODE_ASL, 8'hFF, 4'd15, 8'h00, 1'b0, 1'b0, 1'b0},
      '{MODE_LSL, 8'h81, 4'd8,  8'h00, 1'b1, 1'b0, 1'b0}
    };
    for (int v = 0; v < 15; v++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_mode  = vecs[v].mode;
      in_data  = vecs[v].data;
      in_shamt = vecs[v].shamt;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL vec%0d_accept: in_ready=%b expected 1", v, in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        @(negedge clk);
        lat++;
        if (out_valid) got = 1'b1;
      end
      checks++;
      if (!got || lat != 2) begin
        failures++;
        $display("FAIL vec%0d_latency: got=%b latency=%0d expected 2", v, got, lat);
      end
      checks++;
      if ({out_data, out_carry, out_ovf, out_err} !==
          {vecs[v].exp_data, vecs[v].exp_c, vecs[v].exp_o, vecs[v].exp_e}) begin
        failures++;
        $display("FAIL vec%0d_result: got data=%h c=%b o=%b e=%b expected data=%h c=%b o=%b e=%b", v,
                 out_data, out_carry, out_ovf, out_err,
                 vecs[v].exp_data, vecs[v].exp_c, vecs[v].exp_o, vecs[v].exp_e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nacc = 0, nout = 0;
    int first_acc = -1, first_out = -1, last_out = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      if (nacc < 16) begin
        in_valid = 1'b1;
        in_mode  = 3'($urandom_range(0, 7));
        in_shamt = 4'($urandom_range(0, 15));
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (first_acc < 0) first_acc = cyc;
        nacc++;
      end
      if (out_valid) begin
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        nout++;
      end
    end
    checks++;
    if (first_acc < 0 || first_out - first_acc != 2) begin
      failures++;
      $display("FAIL b2b_first_latency: got %0d cycles expected 2", first_out - first_acc);
    end
    checks++;
    if (nout != 16 || last_out - first_out != 15) begin
      failures++;
      $display("FAIL b2b_throughput: got %0d beats over %0d cycles expected 16 over 16", nout, last_out - first_out + 1);
    end
  endtask

  task automatic test_stall();
    int   nacc = 0, nout = 0;
    logic stall;
    logic [11:0] held = '0;
    for (int cyc = 0; cyc < 40 && nout < 12; cyc++) begin
      @(posedge clk); #1;
      stall     = (cyc >= 5 && cyc < 9);
      out_ready = ~stall;
      if (nacc < 12) begin
        in_valid = 1'b1;
        in_data  = 8'(nacc * 37 + 5);
        in_shamt = 4'(nacc * 7);
        in_mode  = 3'(nacc);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (stall) begin
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready: cycle %0d got %b expected 0", cyc, in_ready); end
        if (cyc == 5) begin
          held = {out_valid, out_data, out_carry, out_ovf, out_err};
          checks++;
          if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid: got %b expected 1", out_valid); end
        end else begin
          checks++;
          if ({out_valid, out_data, out_carry, out_ovf, out_err} !== held) begin
            failures++;
            $display("FAIL stall_hold: cycle %0d got %h expected %h", cyc,
                     {out_valid, out_data, out_carry, out_ovf, out_err}, held);
          end
        end
      end
      if (in_valid && in_ready) nacc++;
      if (out_valid && out_ready) nout++;
    end
    checks++;
    if (nacc != 12 || nout != 12) begin
      failures++;
      $display("FAIL stall_count: accepted=%0d delivered=%0d expected 12 and 12", nacc, nout);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    int   lat;
    logic got;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_mode = MODE_LSL; in_data = 8'h11; in_shamt = 4'd1;
    @(posedge clk); #1;
    in_data = 8'h22; in_shamt = 4'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_mid_inflight: out_valid=%b expected 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    sb.delete();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_flush: out_valid=%b expected 0", out_valid); end
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_mode = MODE_ROR; in_data = 8'h01; in_shamt = 4'd1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_idle: out_valid=%b in_ready=%b expected 0 and 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (out_valid) got = 1'b1;
    end
    checks++;
    if (!got || lat != 2) begin failures++; $display("FAIL rst_mid_latency: got=%b latency=%0d expected 2", got, lat); end
    checks++;
    if ({out_data, out_carry} !== {8'h80, 1'b1}) begin
      failures++;
      $display("FAIL rst_mid_result: got data=%h c=%b expected data=80 c=1", out_data, out_carry);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover: %0d beats never delivered expected 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
